// File: rtl/flags_stack_reg.sv
// flags_stack_reg: condition-flag register for the Nibbler datapath.
// It holds NFLAGS live flags with per-bit load enables and a DEPTH-entry LIFO
// that saves and restores the flags across calls and interrupts.
// Overflow and underflow are reported through sticky error bits.
module flags_stack_reg #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NFLAGS-1:0]          flagsIn,
  input  logic [NFLAGS-1:0]          flagsWe,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clearAll,
  input  logic                       errClear,
  output logic [NFLAGS-1:0]          flagsOut,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic [1:0]                 err
);

  localparam int DW = $clog2(DEPTH + 1);
  // Index width into the stack array. It is never wider than the depth counter.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [1:0]        err_q, err_d;
  logic [NFLAGS-1:0] stack_mem [DEPTH];

  logic [NFLAGS-1:0] flags_load;
  logic [DW-1:0]     depth_m1;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;
  logic              is_full;
  logic              is_empty;
  logic              do_push;
  logic              set_ovf;
  logic              set_unf;

  // Derive the fill status, the stack indices and the per-bit load result.
  always_comb begin
    is_full    = (depth_q == DW'(DEPTH));
    is_empty   = (depth_q == '0);
    depth_m1   = depth_q - DW'(1);
    top_idx    = depth_m1[IW-1:0];
    push_idx   = depth_q[IW-1:0];
    flags_load = (flags_q & ~flagsWe) | (flagsIn & flagsWe);
  end

  // Select the next state. The priority, highest first, is:
  // clearAll, then push+pop, then pop, then push, then load.
  always_comb begin
    flags_d = flags_q;
    depth_d = depth_q;
    do_push = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (clearAll) begin
      flags_d = '0;
    end else if (push && pop) begin
      // The two requests cancel. The stack is untouched and the load still applies.
      flags_d = flags_load;
    end else if (pop) begin
      if (!is_empty) begin
        // The restored value takes the place of any load in this cycle.
        flags_d = stack_mem[top_idx];
        depth_d = depth_m1;
      end else begin
        set_unf = 1'b1;
        flags_d = flags_load;
      end
    end else if (push) begin
      flags_d = flags_load;
      if (!is_full) begin
        do_push = 1'b1;
        depth_d = depth_q + DW'(1);
      end else begin
        set_ovf = 1'b1;
      end
    end else begin
      flags_d = flags_load;
    end
    // A new error takes precedence over errClear in the same cycle.
    err_d = (err_q & {2{~errClear}}) | {set_unf, set_ovf};
  end

  // Live flags, depth and sticky errors. These registers reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= '0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage has no reset. Its contents cannot be observed while depth is 0.
  // A push stores the flags as they were before this cycle's load.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[push_idx] <= flags_q;
    end
  end

  // Drive the outputs from registered state only.
  always_comb begin
    flagsOut = flags_q;
    depth    = depth_q;
    err      = err_q;
    full     = is_full;
    empty    = is_empty;
  end

endmodule

// File: tb/tb_flags_stack_reg.sv
// Bench for flags_stack_reg, built with NFLAGS=4 and DEPTH=2.
// Table vectors and one asynchronous-reset sequence feed an expected-value queue.
// Each queued value is compared with the DUT after the following clock edge.
module tb_flags_stack_reg;

  localparam int NF = 4;
  localparam int DP = 2;
  localparam int DW = $clog2(DP + 1);
  localparam int OW = NF + DW + 4;

  logic          clk;
  logic          rst;
  logic [NF-1:0] flags_in;
  logic [NF-1:0] flags_we;
  logic          push;
  logic          pop;
  logic          clear_all;
  logic          err_clear;
  logic [NF-1:0] flags_out;
  logic [DW-1:0] depth;
  logic          full;
  logic          empty;
  logic [1:0]    err;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  flags_stack_reg #(.NFLAGS(NF), .DEPTH(DP)) dut (
    .clk      (clk),
    .reset    (rst),
    .flagsIn  (flags_in),
    .flagsWe  (flags_we),
    .push     (push),
    .pop      (pop),
    .clearAll (clear_all),
    .errClear (err_clear),
    .flagsOut (flags_out),
    .depth    (depth),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          clr;
    logic          psh;
    logic          pp;
    logic          ec;
    logic [NF-1:0] we;
    logic [NF-1:0] fin;
    logic [NF-1:0] ef;
    logic [DW-1:0] ed;
    logic [1:0]    ee;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic clr, input logic psh, input logic pp,
                              input logic ec, input logic [NF-1:0] we,
                              input logic [NF-1:0] fin, input logic [NF-1:0] ef,
                              input logic [DW-1:0] ed, input logic [1:0] ee);
    vec_t v;
    v.clr = clr; v.psh = psh; v.pp = pp; v.ec = ec;
    v.we = we; v.fin = fin; v.ef = ef; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  function automatic logic [OW-1:0] pack_exp(input logic [NF-1:0] f,
                                             input logic [DW-1:0] d,
                                             input logic [1:0] e);
    return {f, d, (d == DW'(DP)), (d == '0), e};
  endfunction

  // Pop the front of the queue and compare it with the current DUT outputs.
  task automatic check_front(input string name);
    logic [OW-1:0] act;
    logic [OW-1:0] exp;
    act = {flags_out, depth, full, empty, err};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected value queued, actual=%b", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: actual {flags,depth,full,empty,err}=%b required=%b",
                 name, act, exp);
      end
    end
  endtask

  // Drive one vector on the falling edge and queue its expected result.
  // The comparison is made 1 time unit after the next rising edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    clear_all = v.clr;
    push      = v.psh;
    pop       = v.pp;
    err_clear = v.ec;
    flags_we  = v.we;
    flags_in  = v.fin;
    exp_q.push_back(pack_exp(v.ef, v.ed, v.ee));
    @(posedge clk);
    #1;
    check_front(name);
  endtask

  task automatic idle_inputs();
    clear_all = 1'b0; push = 1'b0; pop = 1'b0; err_clear = 1'b0;
    flags_we = '0; flags_in = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            clr psh pp  ec  we       fin      exp_f    d  err
    // Reset and load.
    vecs[0]  = mk(0, 0, 0, 0, 4'b0011, 4'b1011, 4'b0011, 0, 2'b00);
    vecs[1]  = mk(0, 0, 0, 0, 4'b1100, 4'b0100, 4'b0111, 0, 2'b00);
    // Push/pop round trip. The push saves 0101 while 1010 is loaded.
    vecs[2]  = mk(0, 0, 0, 0, 4'b1111, 4'b0101, 4'b0101, 0, 2'b00);
    vecs[3]  = mk(0, 1, 0, 0, 4'b1111, 4'b1010, 4'b1010, 1, 2'b00);
    vecs[4]  = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0101, 0, 2'b00);
    // Overflow: push 0001, 0010 and 0011. The third push is dropped.
    vecs[5]  = mk(0, 0, 0, 0, 4'b1111, 4'b0001, 4'b0001, 0, 2'b00);
    vecs[6]  = mk(0, 1, 0, 0, 4'b1111, 4'b0010, 4'b0010, 1, 2'b00);
    vecs[7]  = mk(0, 1, 0, 0, 4'b1111, 4'b0011, 4'b0011, 2, 2'b00);
    vecs[8]  = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0011, 2, 2'b01);
    vecs[9]  = mk(0, 0, 1, 0, 4'b1111, 4'b1111, 4'b0010, 1, 2'b01);
    vecs[10] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 2'b01);
    vecs[11] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 2'b00);
    // Underflow: the load is applied, err[1] is set, then cleared.
    vecs[12] = mk(0, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 2'b00);
    vecs[13] = mk(0, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 0, 2'b10);
    vecs[14] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 2'b00);
    // errClear and a new underflow in the same cycle: the new error stays set.
    vecs[15] = mk(0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0001, 0, 2'b10);
    vecs[16] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 2'b00);
    // Priority A: clearAll beats push, pop and load at depth 1.
    vecs[17] = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1, 2'b00);
    vecs[18] = mk(1, 1, 1, 0, 4'b1111, 4'b1111, 4'b0000, 1, 2'b00);
    // Priority B: push with pop leaves the stack alone and applies the load.
    vecs[19] = mk(0, 1, 1, 0, 4'b0110, 4'b0110, 4'b0110, 1, 2'b00);
    // The stack still holds 0001.
    vecs[20] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 2'b00);
    // Build depth 2 with err = 01 ahead of the asynchronous reset.
    vecs[21] = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1, 2'b00);
    vecs[22] = mk(0, 1, 0, 0, 4'b1000, 4'b1000, 4'b1001, 2, 2'b00);
    vecs[23] = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b1001, 2, 2'b01);
    // After the reset, a pop at depth 0 sets err[1].
    vecs[24] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b10);

    // Reset: release it on a falling edge and check the idle state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back(pack_exp(4'b0000, 0, 2'b00));
    check_front("reset_state");

    for (int i = 0; i < 24; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Assert reset between edges and check that it takes effect at once.
    @(negedge clk);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(pack_exp(4'b0000, 0, 2'b00));
    check_front("async_reset");
    #1;
    rst = 1'b0;

    apply(vecs[24], "vec24_pop_after_reset");

    @(negedge clk);
    idle_inputs();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
